// File: rtl/seq_alu.sv
// Registered handshaked ALU with NZCV flags; optional iterative MUL under `SEQ_ALU_MUL_EN.
// Latency: 1 cycle for single-cycle ops, WIDTH cycles for MUL.
// Backpressure: in_ready drops while MUL iterates; in_valid without in_ready is ignored.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int CMD_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CMD_W-1:0] exe_cmd,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             carry,
    input  logic             s_en,
    output logic             out_valid,
    output logic [WIDTH-1:0] alu_res,
    output logic [3:0]       status_bits
);

    localparam logic [CMD_W-1:0] CMD_MOV = CMD_W'(4'b0001);
    localparam logic [CMD_W-1:0] CMD_MVN = CMD_W'(4'b1001);
    localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(4'b0010);
    localparam logic [CMD_W-1:0] CMD_ADC = CMD_W'(4'b0011);
    localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(4'b0100);
    localparam logic [CMD_W-1:0] CMD_SBC = CMD_W'(4'b0101);
    localparam logic [CMD_W-1:0] CMD_AND = CMD_W'(4'b0110);
    localparam logic [CMD_W-1:0] CMD_ORR = CMD_W'(4'b0111);
    localparam logic [CMD_W-1:0] CMD_EOR = CMD_W'(4'b1000);

    logic [WIDTH-1:0] alu_res_q, alu_res_d;
    logic             out_valid_q, out_valid_d;
    logic [3:0]       status_q, status_d;

    logic [WIDTH-1:0] b_in;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] sc_res;
    logic             sc_ok;
    logic             arith;
    logic [3:0]       sc_flags;
    logic             accept;

    // Subtraction is op1 + ~op2 + cin, so sum[WIDTH] is already the no-borrow carry.
    always_comb begin
        b_in  = op2;
        cin   = 1'b0;
        arith = 1'b0;
        case (exe_cmd)
            CMD_ADD: arith = 1'b1;
            CMD_ADC: begin arith = 1'b1; cin = carry; end
            CMD_SUB: begin arith = 1'b1; b_in = ~op2; cin = 1'b1; end
            CMD_SBC: begin arith = 1'b1; b_in = ~op2; cin = carry; end
            default: ;
        endcase
        sum = {1'b0, op1} + {1'b0, b_in} + {{WIDTH{1'b0}}, cin};

        sc_res = '0;
        sc_ok  = 1'b1;
        case (exe_cmd)
            CMD_MOV: sc_res = op2;
            CMD_MVN: sc_res = ~op2;
            CMD_ADD, CMD_ADC, CMD_SUB, CMD_SBC: sc_res = sum[WIDTH-1:0];
            CMD_AND: sc_res = op1 & op2;
            CMD_ORR: sc_res = op1 | op2;
            CMD_EOR: sc_res = op1 ^ op2;
            default: sc_ok = 1'b0;
        endcase

        sc_flags = status_q;
        if (sc_ok && s_en) begin
            sc_flags[3] = sc_res[WIDTH-1];
            sc_flags[2] = (sc_res == '0);
            if (arith) begin
                sc_flags[1] = sum[WIDTH];
                sc_flags[0] = (op1[WIDTH-1] == b_in[WIDTH-1]) && (sum[WIDTH-1] != op1[WIDTH-1]);
            end
        end
    end

`ifdef SEQ_ALU_MUL_EN
    localparam logic [CMD_W-1:0] CMD_MUL = CMD_W'(4'b1010);
    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic {S_IDLE, S_MUL_BUSY} state_t;

    state_t           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic             mul_s_q, mul_s_d;
    logic [WIDTH-1:0] acc_nxt;

    assign in_ready = in_ready_q;
    assign acc_nxt  = acc_q + (mplier_q[0] ? mcand_q : '0);
`else
    assign in_ready = 1'b1;
`endif

    assign accept = in_valid && in_ready;

    always_comb begin
        alu_res_d   = alu_res_q;
        out_valid_d = 1'b0;
        status_d    = status_q;
`ifdef SEQ_ALU_MUL_EN
        state_d    = state_q;
        in_ready_d = in_ready_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        mul_s_d    = mul_s_q;
        if (state_q == S_IDLE) begin
            if (accept) begin
                if (exe_cmd == CMD_MUL) begin
                    state_d    = S_MUL_BUSY;
                    in_ready_d = 1'b0;
                    cnt_d      = CNT_W'(WIDTH);
                    acc_d      = '0;
                    mcand_d    = op1;
                    mplier_d   = op2;
                    mul_s_d    = s_en;
                end else begin
                    alu_res_d   = sc_res;
                    out_valid_d = 1'b1;
                    status_d    = sc_flags;
                end
            end
        end else begin
            // One shift-add step per busy cycle; only the low WIDTH product bits are kept.
            acc_d    = acc_nxt;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                alu_res_d   = acc_nxt;
                out_valid_d = 1'b1;
                if (mul_s_q) begin
                    status_d[3] = acc_nxt[WIDTH-1];
                    status_d[2] = (acc_nxt == '0);
                end
            end
        end
`else
        if (accept) begin
            alu_res_d   = sc_res;
            out_valid_d = 1'b1;
            status_d    = sc_flags;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res_q   <= '0;
            out_valid_q <= 1'b0;
            status_q    <= 4'b0000;
`ifdef SEQ_ALU_MUL_EN
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            mul_s_q     <= 1'b0;
`endif
        end else begin
            alu_res_q   <= alu_res_d;
            out_valid_q <= out_valid_d;
            status_q    <= status_d;
`ifdef SEQ_ALU_MUL_EN
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            mul_s_q     <= mul_s_d;
`endif
        end
    end

    assign alu_res     = alu_res_q;
    assign out_valid   = out_valid_q;
    assign status_bits = status_q;

endmodule
